// File: rtl/sargantana_icache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sargantana_icache_pkg: shared iFill widths, FSM encoding and helpers.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sargantana_icache_pkg;

  localparam int unsigned IFILL_PADDR_SIZE = 40;
  localparam int unsigned IFILL_LINE_WIDTH = 512;
  localparam int unsigned IFILL_BEAT_WIDTH = 128;

  localparam int unsigned LINE_OFFSET_BITS = $clog2(IFILL_LINE_WIDTH / 8);
  localparam int unsigned NBEATS           = IFILL_LINE_WIDTH / IFILL_BEAT_WIDTH;

  // Flattened iFill interface widths: req = {valid, paddr},
  // resp = {ack, valid, data, inv_valid, inv_paddr}.
  localparam int unsigned IFILL_REQ_W  = 1 + IFILL_PADDR_SIZE;
  localparam int unsigned IFILL_RESP_W = 2 + IFILL_LINE_WIDTH + 1 + IFILL_PADDR_SIZE;

  typedef logic [1:0] ifill_state_t;

  localparam ifill_state_t IDLE    = 2'd0;
  localparam ifill_state_t ISSUE   = 2'd1;
  localparam ifill_state_t COLLECT = 2'd2;
  localparam ifill_state_t RESPOND = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sargantana_ifill_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sargantana_ifill_line_buffer: beat counter plus line assembly register.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sargantana_ifill_line_buffer #(
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned BEAT_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [BEAT_WIDTH-1:0] wr_data_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  last_o,
  output logic                  full_o
);

  localparam int unsigned NB = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]         cnt_q,  cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  full_q, full_d;

  assign last_o = (cnt_q == CW'(NB - 1));

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    full_d = full_q;
    if (clear_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (wr_en_i && !full_q) begin
      for (int b = 0; b < NB; b++) begin
        if (cnt_q == CW'(b)) begin
          line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = wr_data_i;
        end
      end
      cnt_d  = last_o ? '0 : cnt_q + CW'(1);
      full_d = last_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
      full_q <= full_d;
    end
  end

  // Exposes the line with the beat written this cycle already merged in,
  // so the responder can capture a complete line on the final beat.
  assign line_o = line_d;
  assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/sargantana_ifill_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sargantana_ifill_responder: iFill responder fetching lines by beats.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sargantana_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_SIZE = IFILL_PADDR_SIZE,
  parameter int unsigned LINE_WIDTH = IFILL_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = IFILL_BEAT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  ifill_req_valid_i,
  input  logic [PADDR_SIZE-1:0] ifill_req_paddr_i,
  output logic                  ifill_resp_ack_o,
  output logic                  ifill_resp_valid_o,
  output logic [LINE_WIDTH-1:0] ifill_resp_data_o,
  output logic                  ifill_resp_inv_valid_o,
  output logic [PADDR_SIZE-1:0] ifill_resp_inv_paddr_o,
  input  logic                  inv_req_valid_i,
  input  logic [PADDR_SIZE-1:0] inv_req_paddr_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PADDR_SIZE-1:0] mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BEAT_WIDTH-1:0] mem_resp_data_i
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [PADDR_SIZE-1:0] ALIGN_MASK =
    {{(PADDR_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  ifill_state_t          state_q,     state_d;
  logic [PADDR_SIZE-1:0] addr_q,      addr_d;
  logic                  ack_q,       ack_d;
  logic                  abort_q,     abort_d;
  logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  inv_valid_q, inv_valid_d;
  logic [PADDR_SIZE-1:0] inv_paddr_q, inv_paddr_d;

  logic                  buf_clear;
  logic                  buf_wr;
  logic                  buf_last;
  logic                  buf_full;
  logic [LINE_WIDTH-1:0] buf_line;

  sargantana_ifill_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_line_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (buf_clear),
    .wr_en_i   (buf_wr),
    .wr_data_i (mem_resp_data_i),
    .line_o    (buf_line),
    .last_o    (buf_last),
    .full_o    (buf_full)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ack_d       = 1'b0;
    abort_d     = abort_q;
    resp_data_d = resp_data_q;
    buf_clear   = 1'b0;
    // Beats outside COLLECT belong to a dropped transaction and are ignored.
    buf_wr      = (state_q == COLLECT) && mem_resp_valid_i && !buf_full;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (ifill_req_valid_i && !flush_i) begin
          addr_d  = ifill_req_paddr_i & ALIGN_MASK;
          ack_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A flush coinciding with the handshake cannot recall the request,
        // so the line is still drained, just never returned.
        if (mem_req_ready_i) begin
          buf_clear = 1'b1;
          abort_d   = flush_i;
          state_d   = COLLECT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (flush_i) begin
          abort_d = 1'b1;
        end
        if (buf_wr && buf_last) begin
          if (abort_q || flush_i) begin
            state_d = IDLE;
          end else begin
            resp_data_d = buf_line;
            state_d     = RESPOND;
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    inv_valid_d = inv_req_valid_i;
    inv_paddr_d = inv_paddr_q;
    if (inv_req_valid_i) begin
      inv_paddr_d = inv_req_paddr_i & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ack_q       <= 1'b0;
      abort_q     <= 1'b0;
      resp_data_q <= '0;
      inv_valid_q <= 1'b0;
      inv_paddr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ack_q       <= ack_d;
      abort_q     <= abort_d;
      resp_data_q <= resp_data_d;
      inv_valid_q <= inv_valid_d;
      inv_paddr_q <= inv_paddr_d;
    end
  end

  assign ifill_resp_ack_o       = ack_q;
  assign ifill_resp_valid_o     = (state_q == RESPOND);
  assign ifill_resp_data_o      = resp_data_q;
  assign ifill_resp_inv_valid_o = inv_valid_q;
  assign ifill_resp_inv_paddr_o = inv_paddr_q;
  assign mem_req_valid_o        = (state_q == ISSUE);
  assign mem_req_addr_o         = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sargantana_ifill_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sargantana_ifill_responder: directed vector bench for the responder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sargantana_ifill_responder;

  localparam int PA = 40;
  localparam int LW = 512;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic [PA-1:0] req_paddr;
  logic          ack;
  logic          rv;
  logic [LW-1:0] data;
  logic          iv;
  logic [PA-1:0] ipaddr;
  logic          inv_valid;
  logic [PA-1:0] inv_paddr;
  logic          mv;
  logic          ready;
  logic [PA-1:0] maddr;
  logic          bvalid;
  logic [BW-1:0] bdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sargantana_ifill_responder dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .flush_i                (flush),
    .ifill_req_valid_i      (req_valid),
    .ifill_req_paddr_i      (req_paddr),
    .ifill_resp_ack_o       (ack),
    .ifill_resp_valid_o     (rv),
    .ifill_resp_data_o      (data),
    .ifill_resp_inv_valid_o (iv),
    .ifill_resp_inv_paddr_o (ipaddr),
    .inv_req_valid_i        (inv_valid),
    .inv_req_paddr_i        (inv_paddr),
    .mem_req_valid_o        (mv),
    .mem_req_ready_i        (ready),
    .mem_req_addr_o         (maddr),
    .mem_resp_valid_i       (bvalid),
    .mem_resp_data_i        (bdata)
  );

  typedef struct {
    logic          req;
    logic [PA-1:0] paddr;
    logic          flush;
    logic          ready;
    logic          bv;
    logic [BW-1:0] bd;
    logic          inv;
    logic [PA-1:0] ipa;
    logic          e_ack;
    logic          e_mv;
    logic [PA-1:0] e_maddr;
    logic          e_rv;
    logic          chk_data;
    logic          e_iv;
    logic [PA-1:0] e_ipa;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    req_valid = 1'b0;
    req_paddr = '0;
    inv_valid = 1'b0;
    inv_paddr = '0;
    ready     = 1'b0;
    bvalid    = 1'b0;
    bdata     = '0;
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [BW-1:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < 4; k++) l[k*BW +: BW] = base + BW'(k);
    return l;
  endfunction

  // Two fills back to back: A requested at cycle 0, B raised from b_start and
  // held until acked. Memory is always ready; B's beats land in cycles 9..12.
  task automatic two_fills(input string nm, input logic [PA-1:0] pa, input logic [PA-1:0] pb,
                           input int b_start, input int flush_c, input logic [15:0] a_mask,
                           input int exp_rv_n, input int exp_first_rv, input logic [PA-1:0] exp_addr_b);
    int            n_rv = 0;
    int            first_rv = -1;
    int            last_rv = -1;
    int            ack_b = -1;
    int            a_idx = 0;
    logic          b_acked = 1'b0;
    logic [PA-1:0] maddr_b = '0;
    logic [LW-1:0] d_first = '0;
    logic [LW-1:0] d_last = '0;
    for (int c = 0; c < 15; c++) begin
      idle_inputs();
      ready = 1'b1;
      if (c < 2) begin
        req_valid = 1'b1;
        req_paddr = pa;
      end else if (c >= b_start && !b_acked) begin
        req_valid = 1'b1;
        req_paddr = pb;
      end
      flush = (c == flush_c);
      if (a_mask[c]) begin
        bvalid = 1'b1;
        bdata  = 128'hA0 + 128'(a_idx);
        a_idx++;
      end else if (c >= 9 && c <= 12) begin
        bvalid = 1'b1;
        bdata  = 128'hB0 + 128'(c - 9);
      end
      @(negedge clk);
      if (ack && c >= 2 && !b_acked) begin
        b_acked = 1'b1;
        ack_b   = c;
        maddr_b = maddr;
      end
      if (rv) begin
        n_rv++;
        if (first_rv < 0) begin
          first_rv = c;
          d_first  = data;
        end
        last_rv = c;
        d_last  = data;
      end
      tick();
    end
    chk({nm, " resp count"}, LW'(n_rv), LW'(exp_rv_n));
    chk({nm, " first resp cycle"}, LW'(first_rv), LW'(exp_first_rv));
    chk({nm, " second ack cycle"}, LW'(ack_b), LW'(8));
    chk({nm, " second fill addr"}, LW'(maddr_b), LW'(exp_addr_b));
    chk({nm, " last resp cycle"}, LW'(last_rv), LW'(13));
    chk({nm, " last resp data"}, d_last, mk_line(128'hB0));
    if (exp_rv_n == 2) chk({nm, " first resp data"}, d_first, mk_line(128'hA0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] exp_a;
    logic          ok;
    int            n_ack;
    int            n_rv;
    int            rv_c;
    int            ack_c;
    logic          acked;
    logic [PA-1:0] maddr_c;
    logic [LW-1:0] d_c;

    exp_a = {128'hD, 128'hC, 128'hB, 128'hA};
    //          req paddr            fl rdy bv bd      inv ipa             ack mv maddr            rv dat iv e_ipa
    tbl[0] = '{1'b1, 40'h80001234, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 40'h0,         1'b0, 1'b0, 40'h0,        1'b0, 1'b0, 1'b0, 40'h0};
    tbl[1] = '{1'b1, 40'h80001234, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 40'h0,         1'b1, 1'b1, 40'h80001200, 1'b0, 1'b0, 1'b0, 40'h0};
    tbl[2] = '{1'b0, 40'h0,        1'b0, 1'b1, 1'b1, 128'hA, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b0, 1'b0, 40'h0};
    tbl[3] = '{1'b0, 40'h0,        1'b0, 1'b1, 1'b1, 128'hB, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b0, 1'b0, 40'h0};
    tbl[4] = '{1'b0, 40'h0,        1'b0, 1'b1, 1'b1, 128'hC, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b0, 1'b0, 40'h0};
    tbl[5] = '{1'b0, 40'h0,        1'b0, 1'b1, 1'b1, 128'hD, 1'b1, 40'h80000040,  1'b0, 1'b0, 40'h80001200, 1'b0, 1'b0, 1'b0, 40'h0};
    tbl[6] = '{1'b0, 40'h0,        1'b0, 1'b0, 1'b0, 128'h0, 1'b1, 40'h80000080,  1'b0, 1'b0, 40'h80001200, 1'b1, 1'b1, 1'b1, 40'h80000040};
    tbl[7] = '{1'b0, 40'h0,        1'b0, 1'b0, 1'b0, 128'h0, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b1, 1'b1, 40'h80000080};
    tbl[8] = '{1'b1, 40'h90000000, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b1, 1'b0, 40'h0};
    tbl[9] = '{1'b0, 40'h0,        1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 40'h0,         1'b0, 1'b0, 40'h80001200, 1'b0, 1'b1, 1'b0, 40'h0};

    rst = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    chk("reset ack", LW'(ack), LW'(0));
    chk("reset resp valid", LW'(rv), LW'(0));
    chk("reset mem req valid", LW'(mv), LW'(0));
    chk("reset inv valid", LW'(iv), LW'(0));
    chk("reset mem addr", LW'(maddr), LW'(0));
    chk("reset resp data", data, LW'(0));
    chk("reset inv paddr", LW'(ipaddr), LW'(0));
    rst = 1'b0;
    tick();

    // Basic fill with overlapping invalidations, then a flushed request.
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].req;
      req_paddr = tbl[i].paddr;
      flush     = tbl[i].flush;
      ready     = tbl[i].ready;
      bvalid    = tbl[i].bv;
      bdata     = tbl[i].bd;
      inv_valid = tbl[i].inv;
      inv_paddr = tbl[i].ipa;
      @(negedge clk);
      chk($sformatf("row%0d ack", i), LW'(ack), LW'(tbl[i].e_ack));
      chk($sformatf("row%0d mem req valid", i), LW'(mv), LW'(tbl[i].e_mv));
      chk($sformatf("row%0d mem addr", i), LW'(maddr), LW'(tbl[i].e_maddr));
      chk($sformatf("row%0d resp valid", i), LW'(rv), LW'(tbl[i].e_rv));
      chk($sformatf("row%0d inv valid", i), LW'(iv), LW'(tbl[i].e_iv));
      if (tbl[i].chk_data) chk($sformatf("row%0d resp data", i), data, exp_a);
      if (tbl[i].e_iv) chk($sformatf("row%0d inv paddr", i), LW'(ipaddr), LW'(tbl[i].e_ipa));
      tick();
    end

    // Backpressure: ready low for cycles 1..5, beats every third cycle.
    idle_inputs();
    req_valid = 1'b1;
    req_paddr = 40'h0012345678;
    @(negedge clk);
    tick();
    ok    = 1'b1;
    n_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      req_valid = (k == 1);
      ready     = (k == 6);
      @(negedge clk);
      if (!(mv === 1'b1 && maddr === 40'h0012345640)) ok = 1'b0;
      if (ack === 1'b1) n_ack++;
      if (k == 1) chk("bp ack", LW'(ack), LW'(1));
      tick();
    end
    chk("bp req held stable", LW'(ok), LW'(1));
    chk("bp ack count", LW'(n_ack), LW'(1));
    ok    = 1'b1;
    n_rv  = 0;
    rv_c  = -1;
    d_c   = '0;
    for (int j = 0; j < 14; j++) begin
      idle_inputs();
      if (j % 3 == 0 && j < 12) begin
        bvalid = 1'b1;
        bdata  = 128'h1000 + 128'(j / 3);
      end
      @(negedge clk);
      if (mv !== 1'b0) ok = 1'b0;
      if (rv === 1'b1) begin
        n_rv++;
        rv_c = j;
        d_c  = data;
      end
      tick();
    end
    chk("bp req dropped", LW'(ok), LW'(1));
    chk("bp resp count", LW'(n_rv), LW'(1));
    chk("bp resp cycle", LW'(rv_c), LW'(10));
    chk("bp resp data", d_c, mk_line(128'h1000));

    two_fills("flush", 40'h0000000200, 40'h0040000100, 6, 4, 16'b0000_0000_0110_1100,
              1, 13, 40'h0040000100);
    two_fills("busy", 40'h0030000000, 40'h0050000077, 2, -1, 16'b0000_0000_0011_1100,
              2, 6, 40'h0050000040);

    // Reset in the middle of COLLECT, followed by stray beats.
    n_rv    = 0;
    rv_c    = -1;
    ack_c   = -1;
    acked   = 1'b0;
    maddr_c = '0;
    d_c     = '0;
    for (int c = 0; c < 15; c++) begin
      idle_inputs();
      ready = 1'b1;
      rst   = (c == 4);
      if (c < 2) begin
        req_valid = 1'b1;
        req_paddr = 40'h0060000000;
      end else if (c >= 7 && !acked) begin
        req_valid = 1'b1;
        req_paddr = 40'h0070000010;
      end
      if (c >= 2 && c <= 6) begin
        bvalid = 1'b1;
        bdata  = 128'hC0 + 128'(c);
      end else if (c >= 9 && c <= 12) begin
        bvalid = 1'b1;
        bdata  = 128'hD0 + 128'(c - 9);
      end
      if (c == 4) begin
        inv_valid = 1'b1;
        inv_paddr = 40'h0000001234;
      end
      @(negedge clk);
      if (c == 5) begin
        chk("rst ack", LW'(ack), LW'(0));
        chk("rst mem req valid", LW'(mv), LW'(0));
        chk("rst mem addr", LW'(maddr), LW'(0));
        chk("rst resp data", data, LW'(0));
        chk("rst inv valid", LW'(iv), LW'(0));
        chk("rst inv paddr", LW'(ipaddr), LW'(0));
      end
      if (ack === 1'b1 && c >= 7 && !acked) begin
        acked   = 1'b1;
        ack_c   = c;
        maddr_c = maddr;
      end
      if (rv === 1'b1) begin
        n_rv++;
        rv_c = c;
        d_c  = data;
      end
      tick();
    end
    rst = 1'b0;
    chk("rst next ack cycle", LW'(ack_c), LW'(8));
    chk("rst next fill addr", LW'(maddr_c), LW'(40'h0070000000));
    chk("rst resp count", LW'(n_rv), LW'(1));
    chk("rst resp cycle", LW'(rv_c), LW'(13));
    chk("rst resp data", d_c, mk_line(128'hD0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
